// File: rtl/pc_sequencer_if.sv
// Fetch-side and return-stack-side signals of the TB4004 PC sequencer.
// The master is the sequencer; the slave is the ROM/stack environment around it.
interface pc_sequencer_if;
    logic        byteValid;
    logic [7:0]  byteIn;
    logic        condTrue;
    logic        iszNotZero;
    logic [7:0]  jinAddr;
    logic [11:0] stackPcOut;
    logic        stackPcLoad;
    logic [11:0] pc;
    logic [11:0] retAddr;
    logic        stackPush;
    logic        stackPop;
    logic        instrDone;
    logic        secondByte;
    logic        retFault;

    modport master (
        input  byteValid, byteIn, condTrue, iszNotZero, jinAddr,
               stackPcOut, stackPcLoad,
        output pc, retAddr, stackPush, stackPop, instrDone, secondByte, retFault
    );

    modport slave (
        output byteValid, byteIn, condTrue, iszNotZero, jinAddr,
               stackPcOut, stackPcLoad,
        input  pc, retAddr, stackPush, stackPop, instrDone, secondByte, retFault
    );
endinterface

// File: rtl/pc_sequencer.sv
// TB4004 program-counter sequencer: steps the 12-bit PC through one- and two-byte
// instructions and resolves JUN/JMS/JCN/ISZ/JIN/BBL targets against the return stack.
module pc_sequencer #(
    parameter logic [11:0] RESET_PC = 12'h000
) (
    input  logic           clk,
    input  logic           rstN,
    pc_sequencer_if.master bus
);

    typedef enum logic [1:0] {FETCH1, FETCH2, RET, RET_WAIT} state_t;

    state_t      state_q, state_d;
    logic [11:0] pc_q, pc_d;
    logic [7:0]  op1_q, op1_d;
    logic [11:0] retLatch_q, retLatch_d;
    logic        retFault_q, retFault_d;
    logic        push, pop, done;
    logic [11:0] nxt;

    function automatic logic is_two_byte(input logic [7:0] op);
        case (op[7:4])
            4'h1, 4'h4, 4'h5, 4'h7: is_two_byte = 1'b1;
            4'h2:                   is_two_byte = ~op[0];
            default:                is_two_byte = 1'b0;
        endcase
    endfunction

    function automatic logic is_jin(input logic [7:0] op);
        is_jin = (op[7:4] == 4'h3) && op[0];
    endfunction

    function automatic logic is_bbl(input logic [7:0] op);
        is_bbl = (op[7:4] == 4'hC);
    endfunction

    assign nxt = pc_q + 12'd1;

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state_q    <= FETCH1;
            pc_q       <= RESET_PC;
            op1_q      <= 8'h00;
            retLatch_q <= 12'h000;
            retFault_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            op1_q      <= op1_d;
            retLatch_q <= retLatch_d;
            retFault_q <= retFault_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        op1_d      = op1_q;
        retLatch_d = retLatch_q;
        retFault_d = retFault_q;
        push       = 1'b0;
        pop        = 1'b0;
        done       = 1'b0;
        case (state_q)
            FETCH1: begin
                if (bus.byteValid) begin
                    op1_d = bus.byteIn;
                    if (is_two_byte(bus.byteIn)) begin
                        pc_d    = nxt;
                        state_d = FETCH2;
                    end else if (is_jin(bus.byteIn)) begin
                        // JIN page comes from the address after the instruction
                        pc_d = {nxt[11:8], bus.jinAddr};
                        done = 1'b1;
                    end else if (is_bbl(bus.byteIn)) begin
                        pc_d    = nxt;
                        state_d = RET;
                    end else begin
                        pc_d = nxt;
                        done = 1'b1;
                    end
                end
            end
            FETCH2: begin
                if (bus.byteValid) begin
                    done    = 1'b1;
                    state_d = FETCH1;
                    case (op1_q[7:4])
                        4'h4: pc_d = {op1_q[3:0], bus.byteIn};
                        4'h5: begin
                            push = 1'b1;
                            pc_d = {op1_q[3:0], bus.byteIn};
                        end
                        4'h1:    pc_d = bus.condTrue   ? {nxt[11:8], bus.byteIn} : nxt;
                        4'h7:    pc_d = bus.iszNotZero ? {nxt[11:8], bus.byteIn} : nxt;
                        default: pc_d = nxt;
                    endcase
                end
            end
            RET: begin
                // Capture the top before the stack decrements on this pop
                pop        = 1'b1;
                retLatch_d = bus.stackPcOut;
                state_d    = RET_WAIT;
            end
            RET_WAIT: begin
                done    = 1'b1;
                state_d = FETCH1;
                if (bus.stackPcLoad) pc_d = retLatch_q;
                else                 retFault_d = 1'b1;
            end
            default: state_d = FETCH1;
        endcase
    end

    assign bus.pc         = pc_q;
    assign bus.retAddr    = nxt;
    assign bus.stackPush  = push;
    assign bus.stackPop   = pop;
    assign bus.instrDone  = done;
    assign bus.secondByte = (state_q == FETCH2);
    assign bus.retFault   = retFault_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer with a one-entry return-stack model.
`timescale 1ns/1ps
module tb_pc_sequencer;

    logic clk;
    logic rstN;
    pc_sequencer_if sif();

    pc_sequencer #(.RESET_PC(12'h000)) dut (
        .clk  (clk),
        .rstN (rstN),
        .bus  (sif.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    // Stack model: top captures retAddr on push, goes stale after a pop,
    // load pulse follows pop by one cycle unless withheld.
    logic [11:0] top_q;
    logic        load_q;
    logic        allowLoad;

    always @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            top_q  <= 12'h000;
            load_q <= 1'b0;
        end else begin
            load_q <= sif.stackPop & allowLoad;
            if (sif.stackPush)     top_q <= sif.retAddr;
            else if (sif.stackPop) top_q <= 12'hEEE;
        end
    end

    assign sif.stackPcOut  = top_q;
    assign sif.stackPcLoad = load_q;

    // Values of the combinational outputs sampled in the last step's cycle
    logic        push_s, pop_s, done_s, sb_s;
    logic [11:0] ret_s;

    task automatic step(input logic valid, input logic [7:0] b);
        @(negedge clk);
        sif.byteValid = valid;
        sif.byteIn    = b;
        #1;
        push_s = sif.stackPush;
        pop_s  = sif.stackPop;
        done_s = sif.instrDone;
        sb_s   = sif.secondByte;
        ret_s  = sif.retAddr;
        @(posedge clk);
        #1;
    endtask

    task automatic jump_to(input logic [11:0] a);
        step(1'b1, {4'h4, a[11:8]});
        step(1'b1, a[7:0]);
    endtask

    task automatic test_reset;
        rstN = 1'b0;
        sif.byteValid = 1'b0;
        repeat (2) @(negedge clk);
        n_cmp++; if (sif.pc !== 12'h000) begin n_fail++; $display("FAIL reset_pc: got %h want 000", sif.pc); end
        n_cmp++; if ({sif.stackPush, sif.stackPop, sif.instrDone, sif.secondByte} !== 4'b0000) begin n_fail++;
            $display("FAIL reset_pulses: got %b want 0000", {sif.stackPush, sif.stackPop, sif.instrDone, sif.secondByte}); end
        n_cmp++; if (sif.retFault !== 1'b0) begin n_fail++; $display("FAIL reset_retFault: got %b want 0", sif.retFault); end
        rstN = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 8'h00);
            n_cmp++; if (done_s !== 1'b1) begin n_fail++; $display("FAIL nop_done[%0d]: got %b want 1", i, done_s); end
        end
        n_cmp++; if (sif.pc !== 12'h003) begin n_fail++; $display("FAIL nop_pc: got %h want 003", sif.pc); end
    endtask

    task automatic test_jms_bbl;
        allowLoad = 1'b1;
        jump_to(12'h010);
        step(1'b1, 8'h52);
        n_cmp++; if (push_s !== 1'b0 || done_s !== 1'b0) begin n_fail++; $display("FAIL jms_b1_pulses: got push=%b done=%b want 0 0", push_s, done_s); end
        step(1'b1, 8'h34);
        n_cmp++; if (push_s !== 1'b1) begin n_fail++; $display("FAIL jms_push: got %b want 1", push_s); end
        n_cmp++; if (ret_s !== 12'h012) begin n_fail++; $display("FAIL jms_retAddr: got %h want 012", ret_s); end
        n_cmp++; if (sif.pc !== 12'h234) begin n_fail++; $display("FAIL jms_pc: got %h want 234", sif.pc); end
        step(1'b1, 8'hC0);
        n_cmp++; if (done_s !== 1'b0 || pop_s !== 1'b0) begin n_fail++; $display("FAIL bbl_f1: got done=%b pop=%b want 0 0", done_s, pop_s); end
        step(1'b1, 8'h00);
        n_cmp++; if (pop_s !== 1'b1 || push_s !== 1'b0 || done_s !== 1'b0) begin n_fail++;
            $display("FAIL bbl_ret: got pop=%b push=%b done=%b want 1 0 0", pop_s, push_s, done_s); end
        step(1'b1, 8'h00);
        n_cmp++; if (done_s !== 1'b1 || pop_s !== 1'b0) begin n_fail++; $display("FAIL bbl_wait: got done=%b pop=%b want 1 0", done_s, pop_s); end
        n_cmp++; if (sif.pc !== 12'h012) begin n_fail++; $display("FAIL bbl_pc: got %h want 012", sif.pc); end
        n_cmp++; if (sif.retFault !== 1'b0) begin n_fail++; $display("FAIL bbl_retFault: got %b want 0", sif.retFault); end
    endtask

    task automatic test_jcn_page;
        jump_to(12'h0FE);
        sif.condTrue = 1'b1;
        step(1'b1, 8'h1A);
        n_cmp++; if (sb_s !== 1'b0 || sif.secondByte !== 1'b1) begin n_fail++; $display("FAIL jcn_secondByte: got %b/%b want 0/1", sb_s, sif.secondByte); end
        step(1'b1, 8'h40);
        n_cmp++; if (sif.pc !== 12'h140) begin n_fail++; $display("FAIL jcn_taken_pc: got %h want 140", sif.pc); end
        jump_to(12'h0FE);
        sif.condTrue = 1'b0;
        step(1'b1, 8'h1A);
        step(1'b1, 8'h40);
        n_cmp++; if (sif.pc !== 12'h100) begin n_fail++; $display("FAIL jcn_nottaken_pc: got %h want 100", sif.pc); end
        n_cmp++; if (done_s !== 1'b1) begin n_fail++; $display("FAIL jcn_done: got %b want 1", done_s); end
    endtask

    task automatic test_isz_jin;
        jump_to(12'h3A0);
        sif.iszNotZero = 1'b1;
        step(1'b1, 8'h75);
        step(1'b1, 8'h80);
        n_cmp++; if (sif.pc !== 12'h380) begin n_fail++; $display("FAIL isz_pc: got %h want 380", sif.pc); end
        sif.jinAddr = 8'h9C;
        step(1'b1, 8'h31);
        n_cmp++; if (sif.pc !== 12'h39C) begin n_fail++; $display("FAIL jin_pc: got %h want 39C", sif.pc); end
        n_cmp++; if (done_s !== 1'b1) begin n_fail++; $display("FAIL jin_done: got %b want 1", done_s); end
        // FIM is two bytes and falls through to the next address
        step(1'b1, 8'h20);
        step(1'b1, 8'h55);
        n_cmp++; if (sif.pc !== 12'h39E) begin n_fail++; $display("FAIL fim_pc: got %h want 39E", sif.pc); end
        sif.iszNotZero = 1'b0;
        step(1'b1, 8'h75);
        step(1'b1, 8'h10);
        n_cmp++; if (sif.pc !== 12'h3A0) begin n_fail++; $display("FAIL isz_zero_pc: got %h want 3A0", sif.pc); end
    endtask

    task automatic test_bbl_underflow;
        allowLoad = 1'b0;
        jump_to(12'h200);
        step(1'b1, 8'hC0);
        step(1'b1, 8'h00);
        step(1'b1, 8'h00);
        n_cmp++; if (done_s !== 1'b1) begin n_fail++; $display("FAIL uf_done: got %b want 1", done_s); end
        n_cmp++; if (sif.pc !== 12'h201) begin n_fail++; $display("FAIL uf_pc: got %h want 201", sif.pc); end
        n_cmp++; if (sif.retFault !== 1'b1) begin n_fail++; $display("FAIL uf_retFault: got %b want 1", sif.retFault); end
        step(1'b1, 8'h00);
        n_cmp++; if (sif.pc !== 12'h202) begin n_fail++; $display("FAIL uf_nop_pc: got %h want 202", sif.pc); end
        n_cmp++; if (sif.retFault !== 1'b1) begin n_fail++; $display("FAIL uf_sticky: got %b want 1", sif.retFault); end
        allowLoad = 1'b1;
    endtask

    task automatic test_stall_wrap_reset;
        jump_to(12'hFFF);
        n_cmp++; if (sif.pc !== 12'hFFF) begin n_fail++; $display("FAIL wrap_jun_pc: got %h want FFF", sif.pc); end
        step(1'b1, 8'h00);
        n_cmp++; if (sif.pc !== 12'h000) begin n_fail++; $display("FAIL wrap_pc: got %h want 000", sif.pc); end
        step(1'b1, 8'h4F);
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 8'hFF);
            n_cmp++; if (sb_s !== 1'b1 || done_s !== 1'b0 || push_s !== 1'b0 || sif.pc !== 12'h001) begin n_fail++;
                $display("FAIL stall[%0d]: got sb=%b done=%b push=%b pc=%h want 1 0 0 001", i, sb_s, done_s, push_s, sif.pc); end
        end
        @(negedge clk);
        rstN = 1'b0;
        #1;
        n_cmp++; if (sif.secondByte !== 1'b0) begin n_fail++; $display("FAIL rst_mid_sb: got %b want 0", sif.secondByte); end
        n_cmp++; if (sif.pc !== 12'h000) begin n_fail++; $display("FAIL rst_mid_pc: got %h want 000", sif.pc); end
        n_cmp++; if (sif.retFault !== 1'b0 || sif.instrDone !== 1'b0) begin n_fail++;
            $display("FAIL rst_mid_flags: got retFault=%b done=%b want 0 0", sif.retFault, sif.instrDone); end
        @(negedge clk);
        sif.byteValid = 1'b0;
        rstN = 1'b1;
        step(1'b1, 8'h00);
        n_cmp++; if (sif.pc !== 12'h001) begin n_fail++; $display("FAIL post_rst_pc: got %h want 001", sif.pc); end
    endtask

    initial begin
        rstN           = 1'b0;
        allowLoad      = 1'b1;
        sif.byteValid  = 1'b0;
        sif.byteIn     = 8'h00;
        sif.condTrue   = 1'b0;
        sif.iszNotZero = 1'b0;
        sif.jinAddr    = 8'h00;
        test_reset();
        test_jms_bbl();
        test_jcn_page();
        test_isz_jin();
        test_bbl_underflow();
        test_stall_wrap_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
